// File: rtl/gpio_tester_pkg.sv
// Shared types and helpers for the GPIO header tester.
//   state_t         : tester FSM states
//   mode_t          : peer function selector
//   LFSR_TAPS       : feedback taps of the 16-bit operand generator
//   DEFAULT_SEED    : default LFSR seed (must be nonzero)
//   expected_result : expected peer response for a given mode and operand pair
//   lfsr_next       : one shift of the operand generator
package gpio_tester_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned BYTE_W = 8;

  // Feedback taps: bits 15, 13, 12 and 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_PASS,
    MODE_OR,
    MODE_AND,
    MODE_XOR
  } mode_t;

  // Expected peer response for operands A and B.
  function automatic logic [LFSR_W-1:0] expected_result(input mode_t m,
                                                        input logic [BYTE_W-1:0] a,
                                                        input logic [BYTE_W-1:0] b);
    logic [LFSR_W-1:0] r;
    case (m)
      MODE_PASS: r = {a, b};
      MODE_OR:   r = {8'h00, a | b};
      MODE_AND:  r = {8'h00, a & b};
      default:   r = {8'h00, a ^ b};
    endcase
    return r;
  endfunction

  // Fibonacci shift-left step; new bit0 is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gpio_header_tester_lfsr16.sv
// Load/step 16-bit operand generator.
//   clk, rst_n : clock and async active-low reset (resets to SEED)
//   load       : reload SEED (takes priority over step)
//   step       : advance one position
//   value      : current state
module lfsr16
  import gpio_tester_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q, value_d;

  // Next-state selection.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = SEED;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/gpio_header_tester.sv
// Mating-end tester for the GPIO header demo: drives pseudo-random operand
// bytes on GPIO[15:0], waits a settle interval, then checks the peer's result
// on GPIO[31:16] against the selected function, counting passes and failures.
//   CLOCK_50, Resetn : clock and async active-low reset
//   start, mode      : begin a run with the given peer function
//   GPIO             : [15:0] operands (Z when idle), [31:16] peer result input
//   busy, done       : run status
//   pass_count, fail_count, first_fail : run results
module gpio_header_tester
  import gpio_tester_pkg::*;
#(
  parameter int unsigned       NUM_VECTORS   = 64,
  parameter int unsigned       SETTLE_CYCLES = 4,
  parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
  input  logic        CLOCK_50,
  input  logic        Resetn,
  input  logic        start,
  input  logic [1:0]  mode,
  inout  wire  [31:0] GPIO,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_count,
  output logic [7:0]  fail_count,
  output logic [31:0] first_fail
);

  localparam int unsigned CNT_W = 8;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic [31:0]        first_fail_q, first_fail_d;
  logic               drive_en_q, drive_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               lfsr_load;
  logic               lfsr_step;
  logic [LFSR_W-1:0]  lfsr_value;
  logic [LFSR_W-1:0]  got;
  logic [LFSR_W-1:0]  expected;
  logic               active_d;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  assign got      = GPIO[31:16];
  assign expected = expected_result(mode_q, lfsr_value[15:8], lfsr_value[7:0]);

  // Next-state and result-update logic.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    first_fail_d = first_fail_q;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          mode_d       = mode_t'(mode);
          lfsr_load    = 1'b1;
          pass_d       = '0;
          fail_d       = '0;
          first_fail_d = '0;
          idx_d        = '0;
        end
      end
      ST_DRIVE: begin
        settle_d = CNT_W'(SETTLE_CYCLES);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == CNT_W'(1)) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        // Equality branch counts the pass so an unknown sample lands in fail.
        if (got == expected) begin
          pass_d = pass_q + CNT_W'(1);
        end else begin
          fail_d = fail_q + CNT_W'(1);
          if (fail_q == '0) begin
            first_fail_d = {lfsr_value, got};
          end
        end
        lfsr_step = 1'b1;
        idx_d     = idx_q + CNT_W'(1);
        state_d   = (idx_q == CNT_W'(NUM_VECTORS - 1)) ? ST_DONE : ST_DRIVE;
      end
      default: state_d = ST_IDLE;
    endcase

    active_d   = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    busy_d     = active_d;
    drive_en_d = active_d;
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_PASS;
      idx_q        <= '0;
      settle_q     <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      first_fail_q <= '0;
      drive_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      first_fail_q <= first_fail_d;
      drive_en_q   <= drive_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Operand drivers; the enable flop clears asynchronously so reset releases the bus at once.
  // GPIO[31:16] is never driven here.
  assign GPIO[15:0] = drive_en_q ? lfsr_value : 16'bz;

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gpio_header_tester.sv
// Bench for gpio_header_tester: a registered peer model answers on GPIO[31:16];
// table rows select DUT mode and peer behaviour, an operand scoreboard checks
// each driven vector, and hand sequences cover start-during-run and mid-run reset.
module tb_gpio_header_tester;
  import gpio_tester_pkg::*;

  localparam int unsigned NV      = 64;
  localparam int unsigned SC      = 4;
  localparam int unsigned VEC_CYC = SC + 2;
  localparam int unsigned RUN_CYC = 1 + NV * VEC_CYC;
  localparam logic [15:0] SEED_TB = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  wire  [31:0] gpio;
  logic        busy, done;
  logic [7:0]  pass_count, fail_count;
  logic [31:0] first_fail;

  logic        peer_on = 1'b0;
  logic [1:0]  peer_sw = 2'd0;
  logic [15:0] peer_q  = 16'h0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sw;
    logic        on;
    logic        chk_v0;
    logic [15:0] v0;
    logic        use_model;
    logic [7:0]  pass;
    logic [7:0]  fail;
    logic [31:0] ff;
    logic [31:0] ff_mask;
  } vec_t;

  vec_t tbl [6];

  always #10 clk = ~clk;

  gpio_header_tester #(
    .NUM_VECTORS   (NV),
    .SETTLE_CYCLES (SC),
    .SEED          (SEED_TB)
  ) dut (
    .CLOCK_50   (clk),
    .Resetn     (rst_n),
    .start      (start),
    .mode       (mode),
    .GPIO       (gpio),
    .busy       (busy),
    .done       (done),
    .pass_count (pass_count),
    .fail_count (fail_count),
    .first_fail (first_fail)
  );

  function automatic logic [15:0] peer_fn(input logic [1:0] sw, input logic [7:0] a,
                                          input logic [7:0] b);
    case (sw)
      2'd0:    return {a, b};
      2'd1:    return {8'h00, a | b};
      2'd2:    return {8'h00, a & b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  function automatic logic [15:0] step_tb(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic released(input logic [15:0] v);
    return $isunknown(v) || (v == 16'h0);
  endfunction

  // Demo peer: registers its answer one clock after seeing the operands.
  always @(posedge clk) peer_q <= peer_fn(peer_sw, gpio[15:8], gpio[7:0]);
  assign gpio[31:16] = peer_on ? peer_q : 16'bz;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic run_row(input vec_t r, input int pulse_at, input int stop_at);
    logic [15:0] q[$];
    logic [15:0] s;
    logic [15:0] ev;
    logic [7:0]  a, b;
    int          cyc;
    int          ep, ef;
    s = SEED_TB; ep = 0; ef = 0;
    for (int k = 0; k < int'(NV); k++) begin
      q.push_back(s);
      a = s[15:8]; b = s[7:0];
      if (peer_fn(r.sw, a, b) == expected_result(mode_t'(r.mode), a, b)) ep++;
      else ef++;
      s = step_tb(s);
    end
    if (!r.use_model) begin
      ep = int'(r.pass); ef = int'(r.fail);
    end
    peer_on = r.on; peer_sw = r.sw;
    @(negedge clk);
    mode = r.mode; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (cyc = 1; cyc <= int'(RUN_CYC) + 20; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_at);
      if (cyc == 1) begin
        check("busy_rise", 32'(busy), 32'd1);
        check("counts_cleared", 32'({pass_count, fail_count}), 32'd0);
      end
      if (((cyc - 1) % int'(VEC_CYC)) == 0 && q.size() > 0) begin
        ev = q.pop_front();
        check("operands", 32'(gpio[15:0]), 32'(ev));
      end
      if (cyc == int'(VEC_CYC) && r.chk_v0) check("vec0_result", 32'(gpio[31:16]), 32'(r.v0));
      if (cyc == stop_at) return;
      if (done) break;
    end
    check("done_latency", 32'(cyc), 32'(RUN_CYC));
    check("busy_fall", 32'(busy), 32'd0);
    check("pass_count", 32'(pass_count), 32'(ep));
    check("fail_count", 32'(fail_count), 32'(ef));
    check("first_fail", first_fail & r.ff_mask, r.ff & r.ff_mask);
    check("gpio_release_done", 32'(released(gpio[15:0])), 32'd1);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //         mode  sw    on    chk   v0        model pass   fail   first_fail     mask
    tbl[0] = '{2'd0, 2'd0, 1'b1, 1'b1, 16'hACE1, 1'b0, 8'd64, 8'd0,  32'h0,         32'hFFFF_FFFF};
    tbl[1] = '{2'd1, 2'd1, 1'b1, 1'b1, 16'h00ED, 1'b0, 8'd64, 8'd0,  32'h0,         32'hFFFF_FFFF};
    tbl[2] = '{2'd2, 2'd2, 1'b1, 1'b1, 16'h00A0, 1'b0, 8'd64, 8'd0,  32'h0,         32'hFFFF_FFFF};
    tbl[3] = '{2'd3, 2'd3, 1'b1, 1'b1, 16'h004D, 1'b0, 8'd64, 8'd0,  32'h0,         32'hFFFF_FFFF};
    tbl[4] = '{2'd3, 2'd1, 1'b1, 1'b1, 16'h00ED, 1'b1, 8'd0,  8'd0,  32'hACE1_00ED, 32'hFFFF_FFFF};
    tbl[5] = '{2'd0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0,  8'd64, 32'hACE1_0000, 32'hFFFF_0000};

    // Reset values while held in reset.
    #25;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass_count), 32'd0);
    check("rst_fail", 32'(fail_count), 32'd0);
    check("rst_first_fail", first_fail, 32'd0);
    check("rst_gpio_lo", 32'(released(gpio[15:0])), 32'd1);
    check("rst_gpio_hi", 32'(released(gpio[31:16])), 32'd1);

    // Released without start: stays idle.
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_gpio", 32'(released(gpio[15:0])), 32'd1);

    for (int i = 0; i < 6; i++) run_row(tbl[i], 0, 0);

    // Start pulse during vector 0 settle must not disturb the run.
    run_row(tbl[0], 3, 0);

    // Reset during vector 9 settle, then a clean rerun.
    run_row(tbl[1], 0, 57);
    check("midrun_pass", 32'(pass_count), 32'd9);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_counts", 32'({pass_count, fail_count}), 32'd0);
    check("midrst_first_fail", first_fail, 32'd0);
    check("midrst_gpio", 32'(released(gpio[15:0])), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    run_row(tbl[4], 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_header_tester.md
# gpio_header_tester

Mating-end tester for the 40-pin GPIO header bidirectional demo. It plugs onto the same 32 header lines. It drives operand bytes A (GPIO[15:8]) and B (GPIO[7:0]), then waits a settle interval. It samples the peer's result lines GPIO[31:16] and compares them against the expected pass/OR/AND/XOR function selected by mode, while counting passes and failures over a pseudo-random vector sweep. It sits in a tester top alongside the design under test and reports results on LEDR/HEX.

## Interface
Parameters:
- NUM_VECTORS, 64: vectors per run; range 1..255.
- SETTLE_CYCLES, 4: cycles between driving operands and sampling results; range 1..255.
- SEED, 16'hACE1: LFSR seed; 0 is illegal.

Ports:
- CLOCK_50  in  1: sole clock, rising edge.
- Resetn  in  1: asynchronous, active-low reset.
- start  in  1: begin run; sampled in IDLE or DONE.
- mode  in  2: peer function; latched at start. 0: pass, 1: OR, 2: AND, 3: XOR.
- GPIO  inout  32: header. [15:0] driven by this block when active, otherwise Z. [31:16] is always Z (input only).
- busy  out  1: run in progress.
- done  out  1: run finished; held until the next start or reset.
- pass_count  out  8: vectors matched.
- fail_count  out  8: vectors mismatched.
- first_fail  out  32: {A, B, got[15:0]} of the first mismatch; 0 if there is none.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE → DRIVE when start=1. On that transition: latch mode, load the LFSR with SEED, clear both counters and first_fail, set the vector index to 0.
- start in DRIVE/SETTLE/CHECK is ignored.
- DRIVE (1 cycle): GPIO[15:0] ← LFSR value. A = LFSR[15:8], B = LFSR[7:0]. Load the settle counter with SETTLE_CYCLES.
- SETTLE: hold the operands and decrement the counter. At 1 → CHECK.
- CHECK (1 cycle): compare GPIO[31:16] against expected.
  - Match: pass_count+1.
  - Mismatch: fail_count+1. If this is the first failure, capture first_fail.
  - Then step the LFSR and increment the index. If index == NUM_VECTORS-1 → DONE, else → DRIVE.
- Expected value:
  - mode 0: {A, B}
  - mode 1: {8'h00, A|B}
  - mode 2: {8'h00, A&B}
  - mode 3: {8'h00, A^B}
- LFSR: 16-bit Fibonacci, shifts left. New bit0 = b15^b13^b12^b10. Vector k uses the state after k steps, so vector 0 = SEED.
- Any Z/X sampled on GPIO[31:16] counts as a mismatch (use case-inequality compare in the model; compare as-is in RTL).
- GPIO[15:0] is driven only in DRIVE, SETTLE and CHECK. It is Z in IDLE and DONE.
- Counters never wrap: at most NUM_VECTORS ≤ 255.

## Timing
- Reset values: busy=0, done=0, pass_count=0, fail_count=0, first_fail=0, GPIO all Z, state IDLE.
- Reset mid-run: everything returns to the reset values immediately (asynchronously). The GPIO drivers release in the same instant.
- start high at edge n → DRIVE in cycle n+1. busy=1 from n+1 through the last CHECK.
- Per vector: 1 DRIVE + SETTLE_CYCLES + 1 CHECK cycles.
- done rises (and busy falls) in the cycle after the final CHECK, i.e. at n+1+NUM_VECTORS·(SETTLE_CYCLES+2).
- Counters update at the end of each CHECK and are visible the next cycle.
- start held high in DONE restarts immediately. A continuous start therefore loops runs with one DONE cycle between them.

## Structure
- Package gpio_tester_pkg holds:
  - state_t enum
  - mode_t enum
  - LFSR tap constants and the default seed
  - function expected_result(mode_t, A, B) returning 16 bits, shared with the testbench scoreboard
- Sub-module lfsr16: a load/step LFSR with a SEED parameter, instantiated once.
- Tristate handling uses continuous assigns in the top of this block only.

## Test plan
- Reset check: hold Resetn=0 → all outputs 0, GPIO[31:0] reads Z. Release, with no start → stays IDLE, GPIO Z.
- Good peer, mode 0: connect the demo peer with SW=0, start → done after 1+64·6 cycles, pass_count=64, fail_count=0. Vector 0 drives 16'hACE1 and expects 16'hACE1.
- Good peer, modes 1/2/3: for vector 0 (A=8'hAC, B=8'hE1), GPIO[31:16] is 16'h00ED, 16'h00A0 and 16'h004D respectively. Each run ends with pass_count=64, fail_count=0.
- Mode mismatch: DUT mode=3 with peer SW=1 → fail_count>0. first_fail equals {8'hAC, 8'hE1, 16'h00ED}.
- Unconnected peer (GPIO[31:16] floating Z) → fail_count=64, pass_count=0, first_fail[31:16]=16'hACE1.
- Control edge cases:
  - start pulse during SETTLE is ignored.
  - Resetn low in the 10th vector → immediate reset values. A new start then reruns from SEED with fresh counts.
